// File: rtl/game_pkg.sv
// Shared encodings and widths for the rock-paper-scissors match path.
package game_pkg;

  localparam int unsigned ScoreW = 3;
  localparam int unsigned RoundW = 4;

  typedef enum logic [1:0] {
    MOVE_NONE     = 2'b00,
    MOVE_ROCK     = 2'b01,
    MOVE_PAPER    = 2'b10,
    MOVE_SCISSORS = 2'b11
  } move_e;

  typedef enum logic [1:0] {
    RES_DRAW    = 2'b00,
    RES_P1      = 2'b01,
    RES_P2      = 2'b10,
    RES_INVALID = 2'b11
  } res_e;

  typedef enum logic [2:0] {
    StIdle,
    StCollect,
    StResolve,
    StWaitRes,
    StScore,
    StMatchOver
  } state_e;

endpackage

// File: rtl/rps_move_latch.sv
// Per-player move capture register with a one-cycle ack pulse.
module rps_move_latch
  import game_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  input  logic       valid,
  input  logic [1:0] move,
  output logic       cap,
  output logic       latched,
  output logic [1:0] held_move,
  output logic       ack
);

  // Only the first real move of a round is taken; MOVE_NONE is never captured.
  assign cap = en && valid && (move != MOVE_NONE) && !latched;

  // Capture register and ack pulse; clear has priority over capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latched   <= 1'b0;
      held_move <= MOVE_NONE;
      ack       <= 1'b0;
    end else begin
      ack <= cap && !clr;
      if (clr) begin
        latched   <= 1'b0;
        held_move <= MOVE_NONE;
      end else if (cap) begin
        latched   <= 1'b1;
        held_move <= move;
      end
    end
  end

endmodule

// File: rtl/rps_match_ctrl.sv
// Match sequencer: collects moves, drives the resolve datapath, tallies a best-of match.
module rps_match_ctrl
  import game_pkg::*;
#(
  parameter int unsigned WIN_TARGET  = 3,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              p1_valid,
  input  logic [1:0]        p1_move,
  input  logic              p2_valid,
  input  logic [1:0]        p2_move,
  output logic              p1_ack,
  output logic              p2_ack,
  output logic              res_req,
  output logic [1:0]        res_move_a,
  output logic [1:0]        res_move_b,
  input  logic              res_done,
  input  logic [1:0]        res_win,
  output logic [ScoreW-1:0] score_p1,
  output logic [ScoreW-1:0] score_p2,
  output logic [RoundW-1:0] round_cnt,
  output logic              busy,
  output logic [1:0]        match_winner,
  output logic              match_done
);

  localparam logic [ScoreW-1:0] WinTgt  = ScoreW'(WIN_TARGET);
  localparam logic [16:0]       TmoLast = 17'(TIMEOUT_CYC);

  state_e              state_q, state_d;
  logic [15:0]         tmo_q, tmo_d;
  logic [1:0]          rnd_q, rnd_d;
  logic [ScoreW-1:0]   score_p1_q, score_p1_d, score_p2_q, score_p2_d;
  logic [RoundW-1:0]   round_q, round_d;
  logic [1:0]          winner_q, winner_d;
  logic                done_q, done_d;
  logic                latch_clr, collect_en;
  logic                p1_cap, p2_cap, p1_latched, p2_latched;
  logic                l1_next, l2_next, tmo_hit;
  logic [ScoreW-1:0]   p1_inc, p2_inc;

  assign collect_en = (state_q == StCollect);

  rps_move_latch u_latch_p1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (collect_en),
    .clr      (latch_clr),
    .valid    (p1_valid),
    .move     (p1_move),
    .cap      (p1_cap),
    .latched  (p1_latched),
    .held_move(res_move_a),
    .ack      (p1_ack)
  );

  rps_move_latch u_latch_p2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (collect_en),
    .clr      (latch_clr),
    .valid    (p2_valid),
    .move     (p2_move),
    .cap      (p2_cap),
    .latched  (p2_latched),
    .held_move(res_move_b),
    .ack      (p2_ack)
  );

  assign l1_next = p1_latched || p1_cap;
  assign l2_next = p2_latched || p2_cap;
  assign tmo_hit = (({1'b0, tmo_q} + 17'd1) == TmoLast);
  assign p1_inc  = score_p1_q + ScoreW'(1);
  assign p2_inc  = score_p2_q + ScoreW'(1);

  // Next-state, counters and scoring.
  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    rnd_d      = rnd_q;
    score_p1_d = score_p1_q;
    score_p2_d = score_p2_q;
    round_d    = round_q;
    winner_d   = winner_q;
    done_d     = 1'b0;
    latch_clr  = 1'b0;
    res_req    = 1'b0;

    unique case (state_q)
      StIdle, StMatchOver: begin
        if (start) begin
          state_d    = StCollect;
          tmo_d      = '0;
          latch_clr  = 1'b1;
          score_p1_d = '0;
          score_p2_d = '0;
          round_d    = '0;
          winner_d   = 2'b00;
        end
      end
      StCollect: begin
        if (p1_latched && p2_latched) begin
          state_d = StResolve;
        end else if (tmo_hit) begin
          // A second capture on the timeout edge still goes to resolve next edge.
          if (l1_next && l2_next) begin
            state_d = StCollect;
          end else if (l1_next) begin
            state_d = StScore;
            rnd_d   = RES_P1;
          end else if (l2_next) begin
            state_d = StScore;
            rnd_d   = RES_P2;
          end else begin
            tmo_d = '0;  // void round, nobody moved
          end
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      StResolve: begin
        res_req = 1'b1;
        state_d = StWaitRes;
      end
      StWaitRes: begin
        if (res_done) begin
          rnd_d   = (res_win == RES_INVALID) ? RES_DRAW : res_win;
          state_d = StScore;
        end
      end
      StScore: begin
        if (round_q != '1) round_d = round_q + RoundW'(1);
        if (rnd_q == RES_P1) score_p1_d = p1_inc;
        if (rnd_q == RES_P2) score_p2_d = p2_inc;
        if ((rnd_q == RES_P1) && (p1_inc == WinTgt)) begin
          winner_d = RES_P1;
          done_d   = 1'b1;
          state_d  = StMatchOver;
        end else if ((rnd_q == RES_P2) && (p2_inc == WinTgt)) begin
          winner_d = RES_P2;
          done_d   = 1'b1;
          state_d  = StMatchOver;
        end else begin
          latch_clr = 1'b1;
          tmo_d     = '0;
          state_d   = StCollect;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and match registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      tmo_q      <= '0;
      rnd_q      <= 2'b00;
      score_p1_q <= '0;
      score_p2_q <= '0;
      round_q    <= '0;
      winner_q   <= 2'b00;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      rnd_q      <= rnd_d;
      score_p1_q <= score_p1_d;
      score_p2_q <= score_p2_d;
      round_q    <= round_d;
      winner_q   <= winner_d;
      done_q     <= done_d;
    end
  end

  assign score_p1     = score_p1_q;
  assign score_p2     = score_p2_q;
  assign round_cnt    = round_q;
  assign match_winner = winner_q;
  assign match_done   = done_q;
  assign busy         = (state_q == StCollect) || (state_q == StResolve) ||
                        (state_q == StWaitRes) || (state_q == StScore);

endmodule

// File: tb/tb_rps_match_ctrl.sv
// Bench for rps_match_ctrl: directed rounds plus random matches against a game-rule model.
module tb_rps_match_ctrl;

  localparam int T  = 16;
  localparam int WT = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       p1_valid = 1'b0, p2_valid = 1'b0;
  logic [1:0] p1_move = 2'b00, p2_move = 2'b00;
  logic       p1_ack, p2_ack, res_req;
  logic [1:0] res_move_a, res_move_b;
  logic       res_done = 1'b0;
  logic [1:0] res_win = 2'b00;
  logic [2:0] score_p1, score_p2;
  logic [3:0] round_cnt;
  logic       busy, match_done;
  logic [1:0] match_winner;

  int n_checks = 0;
  int n_pass   = 0;

  // Model of the match: plain counters driven by game rules.
  int m_s1, m_s2, m_rounds, m_winner;

  rps_match_ctrl #(.WIN_TARGET(WT), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .p1_valid(p1_valid), .p1_move(p1_move), .p2_valid(p2_valid), .p2_move(p2_move),
    .p1_ack(p1_ack), .p2_ack(p2_ack), .res_req(res_req),
    .res_move_a(res_move_a), .res_move_b(res_move_b),
    .res_done(res_done), .res_win(res_win),
    .score_p1(score_p1), .score_p2(score_p2), .round_cnt(round_cnt),
    .busy(busy), .match_winner(match_winner), .match_done(match_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rps_outcome(input int a, input int b);
    if (a == b) return 0;
    if ((a == 1 && b == 3) || (a == 2 && b == 1) || (a == 3 && b == 2)) return 1;
    return 2;
  endfunction

  function automatic void model_reset();
    m_s1 = 0; m_s2 = 0; m_rounds = 0; m_winner = 0;
  endfunction

  function automatic void model_apply(input int res);
    if (res == 1) m_s1++;
    if (res == 2) m_s2++;
    if (m_rounds < 15) m_rounds++;
    if (m_s1 == WT) m_winner = 1;
    if (m_s2 == WT) m_winner = 2;
  endfunction

  task automatic check_scores(input string tag);
    chk({tag, ".score_p1"}, score_p1, m_s1);
    chk({tag, ".score_p2"}, score_p2, m_s2);
    chk({tag, ".round_cnt"}, round_cnt, m_rounds);
  endtask

  task automatic check_match_end();
    chk("winner", match_winner, m_winner);
    chk("match_done", match_done, m_winner != 0);
    chk("busy", busy, m_winner == 0);
    if (m_winner != 0) begin
      tick();
      chk("match_done_pulse", match_done, 0);
      p1_valid = 1'b1; p1_move = 2'b01;
      tick();
      chk("no_ack_over", p1_ack, 0);
      p1_valid = 1'b0;
    end
  endtask

  task automatic start_match();
    start = 1'b1;
    tick();
    start = 1'b0;
    model_reset();
    chk("start.busy", busy, 1);
    check_scores("start");
  endtask

  // Both players move (with noise valids); bench acts as the resolve datapath.
  task automatic play_round(input int m1, input int d1, input int m2, input int d2,
                            input bit inval, input int rdly);
    int  mx, res;
    bit  stable;
    mx = (d1 > d2) ? d1 : d2;
    for (int c = 0; c <= mx; c++) begin
      if (c < d1) begin p1_valid = ($urandom % 3) == 0; p1_move = 2'b00; end
      else if (c == d1) begin p1_valid = 1'b1; p1_move = 2'(m1); end
      else begin p1_valid = $urandom % 2; p1_move = 2'($urandom_range(1, 3)); end
      if (c < d2) begin p2_valid = ($urandom % 3) == 0; p2_move = 2'b00; end
      else if (c == d2) begin p2_valid = 1'b1; p2_move = 2'(m2); end
      else begin p2_valid = $urandom % 2; p2_move = 2'($urandom_range(1, 3)); end
      tick();
      chk("p1_ack", p1_ack, c == d1);
      chk("p2_ack", p2_ack, c == d2);
    end
    p1_valid = 1'b0; p2_valid = 1'b0;
    chk("req_early", res_req, 0);
    tick();
    chk("res_req", res_req, 1);
    chk("res_move_a", res_move_a, m1);
    chk("res_move_b", res_move_b, m2);
    tick();
    stable = 1'b1;
    for (int i = 0; i < rdly; i++) begin
      if (res_req !== 1'b0 || res_move_a !== 2'(m1) || res_move_b !== 2'(m2)) stable = 1'b0;
      tick();
    end
    chk("hold_stable", stable, 1);
    res = rps_outcome(m1, m2);
    res_done = 1'b1;
    res_win  = inval ? 2'b11 : 2'(res);
    tick();
    res_done = 1'b0;
    res_win  = 2'($urandom);
    check_scores("pre_score");
    tick();
    model_apply(inval ? 0 : res);
    check_scores("round");
    check_match_end();
  endtask

  // Only one player moves; the round is forfeited to them at the timeout.
  task automatic forfeit_round(input int who, input int d);
    bit saw_req = 1'b0;
    for (int c = 0; c < T; c++) begin
      p1_valid = (who == 1) && (c == d); p1_move = 2'b01;
      p2_valid = (who == 2) && (c == d); p2_move = 2'b10;
      tick();
      if (res_req) saw_req = 1'b1;
      if (c == d) chk(who == 1 ? "ff_ack1" : "ff_ack2", who == 1 ? p1_ack : p2_ack, 1);
    end
    p1_valid = 1'b0; p2_valid = 1'b0;
    tick();
    chk("ff_no_req", saw_req, 0);
    model_apply(who);
    check_scores("forfeit");
    check_match_end();
  endtask

  // Nobody moves for two timeout periods; only empty valids from p1.
  task automatic void_rounds();
    int acks = 0;
    bit saw_req = 1'b0;
    for (int c = 0; c < 2 * T; c++) begin
      p1_valid = $urandom % 2; p1_move = 2'b00;
      tick();
      if (p1_ack || p2_ack) acks++;
      if (res_req) saw_req = 1'b1;
    end
    p1_valid = 1'b0;
    chk("void_acks", acks, 0);
    chk("void_req", saw_req, 0);
    chk("void_busy", busy, 1);
    check_scores("void");
  endtask

  initial begin
    int r, rounds;
    model_reset();
    #12;
    chk("rst.busy", busy, 0);
    chk("rst.res_req", res_req, 0);
    check_scores("rst");
    rst_n = 1'b1;
    tick();
    chk("idle.busy", busy, 0);

    // Rock vs scissors in one cycle, datapath says p1.
    start_match();
    play_round(1, 0, 3, 0, 1'b0, 0);
    // Invalid result with a slow datapath.
    play_round(2, 1, 3, 4, 1'b1, 10);
    forfeit_round(1, 3);
    void_rounds();
    // Second capture lands on the timeout edge.
    play_round(3, 0, 3, T - 1, 1'b0, 2);
    // start mid-match is ignored.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("mid_start.busy", busy, 1);
    check_scores("mid_start");
    // p1 wins until the match closes.
    while (m_winner == 0) play_round(1, 0, 3, 2, 1'b0, 1);

    // Reset during WAIT_RES, then a stale res_done.
    start_match();
    play_round(2, 0, 1, 0, 1'b0, 0);
    p1_valid = 1'b1; p1_move = 2'b01; p2_valid = 1'b1; p2_move = 2'b10;
    tick();
    p1_valid = 1'b0; p2_valid = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("ar.busy", busy, 0);
    chk("ar.res_move_a", res_move_a, 0);
    chk("ar.res_move_b", res_move_b, 0);
    chk("ar.acks", {p1_ack, p2_ack}, 0);
    chk("ar.winner", match_winner, 0);
    check_scores("async_rst");
    tick();
    rst_n = 1'b1;
    tick();
    res_done = 1'b1; res_win = 2'b01;
    tick();
    res_done = 1'b0;
    tick();
    tick();
    chk("late_done.busy", busy, 0);
    chk("late_done.req", res_req, 0);
    check_scores("late_done");

    // Random matches.
    for (int m = 0; m < 3; m++) begin
      start_match();
      rounds = 0;
      while (m_winner == 0 && rounds < 60) begin
        r = $urandom % 10;
        if (r == 0) forfeit_round($urandom_range(1, 2), $urandom_range(0, 10));
        else if (r == 1) void_rounds();
        else play_round($urandom_range(1, 3), $urandom_range(0, 12),
                        $urandom_range(1, 3), $urandom_range(0, 12),
                        ($urandom % 7) == 0, $urandom_range(0, 10));
        rounds++;
      end
      chk("match_ended", m_winner != 0, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rps_match_ctrl.md
Name: rps_match_ctrl

Overview:
Match sequencer for the rock-paper-scissors game path. It collects one move per player per round through a valid/ack handshake and issues each move pair to the existing resolve datapath. It also tallies round results and declares a best-of match winner when a player reaches WIN_TARGET wins. It sits between the player input pins and the resolve datapath; the top-level mux exposes its scores and status.

Parameters:
WIN_TARGET, 3, round wins needed to take the match (1..7)
TIMEOUT_CYC, 255, COLLECT cycles before a round is forfeited or voided (1..65535)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
start  input  1  begin new match; honoured only in IDLE or MATCH_OVER
p1_valid  input  1  player 1 offers a move
p1_move  input  2  player 1 move: 00 none, 01 rock, 10 paper, 11 scissors
p2_valid  input  1  player 2 offers a move
p2_move  input  2  player 2 move, same encoding
p1_ack  output  1  one-cycle pulse: player 1 move captured
p2_ack  output  1  one-cycle pulse: player 2 move captured
res_req  output  1  one-cycle request to the resolve datapath
res_move_a  output  2  player 1 move to datapath, held from res_req until res_done
res_move_b  output  2  player 2 move to datapath, same hold rule
res_done  input  1  datapath result valid
res_win  input  2  00 draw, 01 p1 wins, 10 p2 wins, 11 invalid
score_p1  output  3  player 1 round wins
score_p2  output  3  player 2 round wins
round_cnt  output  4  rounds scored this match, saturates at 15
busy  output  1  high in COLLECT/RESOLVE/WAIT_RES/SCORE
match_winner  output  2  00 none, 01 p1, 10 p2; held until next start
match_done  output  1  one-cycle pulse on entry to MATCH_OVER

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous and active-low. Reset forces the state to IDLE and all outputs, latches and counters to 0, including mid-round and mid-WAIT_RES.
- States: IDLE, COLLECT, RESOLVE, WAIT_RES, SCORE, MATCH_OVER.
- IDLE/MATCH_OVER with start=1: clear scores, round_cnt, latches and timeout counter, then go to COLLECT next cycle. start in any other state is ignored.
- COLLECT, move capture:
  - Each player's move is captured on the first clock edge where valid=1 and move!=00.
  - The matching ack is high for exactly the following cycle.
  - valid with move=00 is not captured and gets no ack.
  - Further valids from an already-latched player are ignored, with no ack.
  - Both players offering in the same cycle: both are captured and both acks fire together.
- COLLECT exit:
  - Once both players are latched, go to RESOLVE on the next edge.
  - The timeout counter increments each COLLECT cycle and restarts on COLLECT entry. When it reaches TIMEOUT_CYC:
    - exactly one player latched: go to SCORE with that player as forced round winner; no res_req is issued.
    - neither latched: round is void; restart the counter and stay in COLLECT; round_cnt is unchanged.
  - If the second capture and the timeout land on the same edge, the capture wins and the round goes to RESOLVE.
- RESOLVE: res_req=1 for one cycle with res_move_a/b driven, then go to WAIT_RES.
- WAIT_RES: wait indefinitely for res_done and sample res_win on that edge. Code 11 is scored as a draw. Then go to SCORE. res_done in any other state is ignored.
- SCORE (one cycle):
  - Increment the winner's score; a draw changes no score.
  - round_cnt+1, saturating at 15.
  - If the incremented score equals WIN_TARGET: set match_winner, pulse match_done, go to MATCH_OVER.
  - Otherwise clear the latches and go to COLLECT.
- MATCH_OVER: scores, round_cnt and match_winner are held; busy=0.
- Latencies:
  - Second capture to res_req: 2 cycles.
  - res_done to updated score visible: 2 cycles.
- Width rules: scores never exceed WIN_TARGET, because the match ends on reaching it.

Decomposition:
- Shared package game_pkg: move encoding (MOVE_NONE/ROCK/PAPER/SCISSORS), result encoding (RES_DRAW/P1/P2/INVALID), the state enum, and the score and round widths.
- One sub-module, rps_move_latch: a per-player capture register with ack pulse and clear input, instantiated twice.

Test Plan:
- Reset then start; p1 rock, p2 scissors in the same cycle -> both acks for 1 cycle; res_req 2 cycles later with a=01, b=11; datapath returns 01 -> score_p1=1, round_cnt=1.
- Three p1 round wins with WIN_TARGET=3 -> match_winner=01, match_done pulses once, busy=0; a further p1_valid gets no ack.
- p1 moves, p2 silent for TIMEOUT_CYC cycles -> no res_req; score_p1 increments; round_cnt=1.
- Neither player moves for 2*TIMEOUT_CYC cycles -> round_cnt=0, state still COLLECT; p1_valid with move=00 -> no ack.
- res_win=11 returned -> scores unchanged, round_cnt+1; res_move_a/b stable from res_req until res_done, with res_done delayed 10 cycles.
- rst_n low during WAIT_RES -> all outputs 0 immediately; a late res_done after release is ignored; start mid-match is ignored.
